// File: rtl/tx_sched_pkg.sv
// Shared types and frame layout for the TX scheduler/arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_CAP   = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    // Arbitration policy encodings
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Frame layout, MSB first: {op_id, ctrl, addr, wr_data}
    localparam int CTRL_W      = 8;
    localparam int OP_ID_W     = 8;
    localparam int CTRL_WR_BIT = 0;
    localparam int OFF_WR_DATA = 0;

    function automatic int frame_width(input int w);
        return 2 * w + CTRL_W + OP_ID_W;
    endfunction

    function automatic int off_addr(input int w);
        return w;
    endfunction

    function automatic int off_ctrl(input int w);
        return 2 * w;
    endfunction

    function automatic int off_op_id(input int w);
        return 2 * w + CTRL_W;
    endfunction

endpackage

// File: rtl/tx_sched_arb_arb.sv
// Combinational channel arbiter: round-robin from ptr_i+1 or fixed lowest-index.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is taken.
module tx_arb
    import tx_sched_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int ARB_MODE = ARB_RR,
    localparam int PW      = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] cand_i,
    input  logic [PW-1:0]     ptr_i,
    output logic              gnt_vld,
    output logic [PW-1:0]     gnt_idx
);

    logic ptr_unused;
    assign ptr_unused = ^ptr_i;

    // Later loop iterations overwrite earlier ones, so iterate from lowest to highest priority
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (cand_i[PW'(i)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                j = int'(ptr_i) + k;
                if (j >= NUM_CH) j = j - NUM_CH;
                if (cand_i[PW'(j)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tx_sched_arb.sv
// Scheduler: picks an eligible channel, pops one FIFO frame and issues it to that switch.
// Latency: grant to issue 3 cycles, one operation every 4 cycles at best.
// Backpressure: a busy switch stalls the issue with the captured frame held.
module tx_sched_arb
    import tx_sched_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int W_WIDTH      = 8,
    parameter int ARB_MODE     = ARB_RR,
    localparam int FRAME_WIDTH = frame_width(W_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             empty_in,
    input  logic [NUM_CH-1:0]             full_in,
    input  logic [NUM_CH-1:0]             sw_busy,
    input  logic [NUM_CH*FRAME_WIDTH-1:0] frame_in,
    output logic [NUM_CH-1:0]             fifo_rd_en,
    output logic [NUM_CH-1:0]             sel_en,
    output logic [W_WIDTH-1:0]            addr,
    output logic [W_WIDTH-1:0]            wr_data,
    output logic                          wr_rd_s,
    output logic [7:0]                    op_id,
    output logic                          op_valid,
    output logic [15:0]                   issue_cnt
);

    localparam int PW        = $clog2(NUM_CH);
    localparam int OFF_ADDR  = off_addr(W_WIDTH);
    localparam int OFF_CTRL  = off_ctrl(W_WIDTH);
    localparam int OFF_OP_ID = off_op_id(W_WIDTH);

    state_t                 state_q, state_d;
    logic [PW-1:0]          gnt_q, gnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;
    logic [15:0]            issue_cnt_q, issue_cnt_d;

    logic [NUM_CH-1:0] elig, urgent, cand, gnt_oh;
    logic              arb_vld;
    logic [PW-1:0]     arb_idx;
    logic [CTRL_W-2:0] ctrl_unused;

    // Full FIFOs among the eligible ones pre-empt everybody else
    assign elig        = ~empty_in & ~sw_busy;
    assign urgent      = elig & full_in;
    assign cand        = (|urgent) ? urgent : elig;
    assign gnt_oh      = NUM_CH'(1) << gnt_q;
    assign ctrl_unused = frame_q[OFF_CTRL + 1 +: CTRL_W - 1];

    tx_arb #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .cand_i  (cand),
        .ptr_i   (ptr_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // FSM next state, frame capture and output decode; reset forces every output low
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        frame_d     = frame_q;
        issue_cnt_d = issue_cnt_q;
        fifo_rd_en  = '0;
        sel_en      = '0;
        addr        = '0;
        wr_data     = '0;
        wr_rd_s     = 1'b0;
        op_id       = '0;
        op_valid    = 1'b0;
        issue_cnt   = issue_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                fifo_rd_en = gnt_oh;
                state_d    = ST_CAP;
            end
            ST_CAP: begin
                // FIFO read data shows up the cycle after the strobe
                for (int k = 0; k < NUM_CH; k++) begin
                    if (gnt_q == PW'(k)) frame_d = frame_in[k*FRAME_WIDTH +: FRAME_WIDTH];
                end
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if ((sw_busy & gnt_oh) == '0) begin
                    sel_en      = gnt_oh;
                    addr        = frame_q[OFF_ADDR +: W_WIDTH];
                    wr_data     = frame_q[OFF_WR_DATA +: W_WIDTH];
                    wr_rd_s     = frame_q[OFF_CTRL + CTRL_WR_BIT];
                    op_id       = frame_q[OFF_OP_ID +: OP_ID_W];
                    op_valid    = 1'b1;
                    issue_cnt_d = (issue_cnt_q == 16'hFFFF) ? issue_cnt_q : issue_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            fifo_rd_en = '0;
            sel_en     = '0;
            addr       = '0;
            wr_data    = '0;
            wr_rd_s    = 1'b0;
            op_id      = '0;
            op_valid   = 1'b0;
            issue_cnt  = '0;
        end
    end

    // State registers; reset drops any operation in flight, popped entry included
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ptr_q       <= PW'(NUM_CH - 1);
            frame_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            frame_q     <= frame_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_sched_arb.sv
// Randomized and directed bench for tx_sched_arb against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_sched_arb;

    localparam int N  = 5;
    localparam int FW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  empty_in, full_in, sw_busy;
    logic [N*FW-1:0] frame_in;

    logic [N-1:0] r_rd, r_sel, f_rd, f_sel;
    logic [7:0]   r_addr, r_wd, r_op, f_addr, f_wd, f_op;
    logic         r_wr, r_ov, f_wr, f_ov;
    logic [15:0]  r_cnt, f_cnt;

    int checks = 0;
    int failures = 0;

    // Model: one operation in flight per instance; age counts cycles since its grant
    int          m_act[2], m_age[2], m_g[2], m_ptr[2];
    int unsigned m_cnt[2];
    logic [31:0] m_frm[2];

    int iss_rr[$], iss_cyc[$], iss_fp[$];
    int cyc = 0;
    int ov_cnt = 0;
    logic [31:0] last_info;

    tx_sched_arb #(.NUM_CH(N), .W_WIDTH(8), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .empty_in(empty_in), .full_in(full_in), .sw_busy(sw_busy),
        .frame_in(frame_in), .fifo_rd_en(r_rd), .sel_en(r_sel), .addr(r_addr),
        .wr_data(r_wd), .wr_rd_s(r_wr), .op_id(r_op), .op_valid(r_ov), .issue_cnt(r_cnt)
    );

    tx_sched_arb #(.NUM_CH(N), .W_WIDTH(8), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .empty_in(empty_in), .full_in(full_in), .sw_busy(sw_busy),
        .frame_in(frame_in), .fifo_rd_en(f_rd), .sel_en(f_sel), .addr(f_addr),
        .wr_data(f_wd), .wr_rd_s(f_wr), .op_id(f_op), .op_valid(f_ov), .issue_cnt(f_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic bit5(input logic [4:0] v, input int k);
        logic [4:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic int oh2idx(input logic [4:0] v);
        for (int k = 0; k < N; k++) if (bit5(v, k)) return k;
        return -1;
    endfunction

    function automatic int qat(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Winner among eligible channels, restricted to full ones when any is full
    function automatic int pick(input int mode, input int ptr, input logic [4:0] e,
                                input logic [4:0] f, input logic [4:0] b);
        logic [4:0] c;
        c = ~e & ~b;
        if ((c & f) != 5'd0) c = c & f;
        if (mode == 1) begin
            for (int k = 0; k < N; k++) if (bit5(c, k)) return k;
        end else begin
            for (int k = 1; k <= N; k++) if (bit5(c, (ptr + k) % N)) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_act[i] = 0; m_age[i] = 0; m_g[i] = 0; m_ptr[i] = N - 1; m_cnt[i] = 0; m_frm[i] = '0;
    endtask

    task automatic model_step(input int i);
        int g;
        logic [N*FW-1:0] sh;
        if (rst) model_reset(i);
        else if (m_act[i] == 0) begin
            g = pick(i, m_ptr[i], empty_in, full_in, sw_busy);
            if (g >= 0) begin
                m_act[i] = 1; m_age[i] = 1; m_g[i] = g; m_ptr[i] = g;
            end
        end else if (m_age[i] == 1) m_age[i] = 2;
        else if (m_age[i] == 2) begin
            sh = frame_in >> (m_g[i] * FW);
            m_frm[i] = sh[FW-1:0];
            m_age[i] = 3;
        end else if (!bit5(sw_busy, m_g[i])) begin
            m_act[i] = 0;
            if (m_cnt[i] < 32'hFFFF) m_cnt[i]++;
        end
    endtask

    task automatic check_out(input int i);
        logic [4:0] e_rd, e_sel, a_rd, a_sel;
        logic [7:0] e_addr, e_wd, e_op, a_addr, a_wd, a_op;
        logic e_wr, e_ov, a_wr, a_ov;
        logic [15:0] e_cnt, a_cnt;
        string p;
        e_rd = '0; e_sel = '0; e_addr = '0; e_wd = '0; e_op = '0; e_wr = 1'b0; e_ov = 1'b0;
        e_cnt = rst ? 16'd0 : m_cnt[i][15:0];
        if (!rst && m_act[i] != 0 && m_age[i] == 1) e_rd = 5'd1 << m_g[i];
        if (!rst && m_act[i] != 0 && m_age[i] == 3 && !bit5(sw_busy, m_g[i])) begin
            e_sel  = 5'd1 << m_g[i];
            e_op   = m_frm[i][31:24];
            e_wr   = m_frm[i][16];
            e_addr = m_frm[i][15:8];
            e_wd   = m_frm[i][7:0];
            e_ov   = 1'b1;
        end
        if (i == 0) begin
            p = "rr"; a_rd = r_rd; a_sel = r_sel; a_addr = r_addr; a_wd = r_wd;
            a_op = r_op; a_wr = r_wr; a_ov = r_ov; a_cnt = r_cnt;
        end else begin
            p = "fp"; a_rd = f_rd; a_sel = f_sel; a_addr = f_addr; a_wd = f_wd;
            a_op = f_op; a_wr = f_wr; a_ov = f_ov; a_cnt = f_cnt;
        end
        check_val({p, ".fifo_rd_en"}, 32'(a_rd), 32'(e_rd));
        check_val({p, ".sel_en"}, 32'(a_sel), 32'(e_sel));
        check_val({p, ".addr"}, 32'(a_addr), 32'(e_addr));
        check_val({p, ".wr_data"}, 32'(a_wd), 32'(e_wd));
        check_val({p, ".op_id"}, 32'(a_op), 32'(e_op));
        check_val({p, ".wr_rd_s"}, 32'(a_wr), 32'(e_wr));
        check_val({p, ".op_valid"}, 32'(a_ov), 32'(e_ov));
        check_val({p, ".issue_cnt"}, 32'(a_cnt), 32'(e_cnt));
    endtask

    // One clock: compare away from the edge, then advance the model with the sampled inputs
    task automatic cycle();
        #1;
        check_out(0);
        check_out(1);
        if (r_sel != '0) begin
            iss_rr.push_back(oh2idx(r_sel));
            iss_cyc.push_back(cyc);
            last_info = {r_op, 7'd0, r_wr, r_addr, r_wd};
        end
        if (r_ov) ov_cnt++;
        if (f_sel != '0) iss_fp.push_back(oh2idx(f_sel));
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        iss_rr.delete(); iss_cyc.delete(); iss_fp.delete(); ov_cnt = 0;
    endtask

    initial begin
        int c0;
        int exp_order[6];
        logic [31:0] orig;
        exp_order = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1; empty_in = '1; full_in = '0; sw_busy = '0; frame_in = '0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        repeat (3) cycle();

        // All channels loaded: round-robin sweep, one issue every 4 cycles
        rst = 1'b0;
        for (int k = 0; k < N; k++) frame_in[k*FW +: FW] = $urandom();
        empty_in = '0;
        clear_log();
        c0 = cyc;
        repeat (24) cycle();
        check_val("rr_issue_count", iss_rr.size(), 6);
        for (int k = 0; k < 6; k++) check_val("rr_order", qat(iss_rr, k), exp_order[k]);
        check_val("rr_first_latency", qat(iss_cyc, 0) - c0, 3);
        for (int k = 1; k < iss_cyc.size(); k++)
            check_val("rr_spacing", iss_cyc[k] - iss_cyc[k-1], 4);
        for (int k = 0; k < iss_fp.size(); k++) check_val("fp_all_ch0", iss_fp[k], 0);

        // Single frame on channel 2, field mapping and latency
        empty_in = 5'b11011;
        frame_in[2*FW +: FW] = 32'hA5013C7E;
        clear_log();
        c0 = cyc;
        cycle();
        empty_in = '1;
        repeat (5) cycle();
        check_val("ch2_issue", qat(iss_rr, 0), 2);
        check_val("ch2_latency", qat(iss_cyc, 0) - c0, 3);
        check_val("ch2_fields", last_info, 32'hA5013C7E);
        check_val("ch2_op_valid_cycles", ov_cnt, 1);

        // Park the pointer on channel 0, then full channel 3 beats channel 1
        empty_in = 5'b11110;
        cycle();
        empty_in = '1;
        repeat (3) cycle();
        empty_in = 5'b10101;
        full_in = 5'b01000;
        clear_log();
        repeat (4) cycle();
        empty_in = 5'b11101;
        full_in = '0;
        repeat (4) cycle();
        empty_in = '1;
        cycle();
        check_val("urgent_first", qat(iss_rr, 0), 3);
        check_val("urgent_second", qat(iss_rr, 1), 1);

        // Channel 4 busy from CAP for 10 cycles; the captured frame must survive
        empty_in = 5'b01111;
        orig = $urandom();
        frame_in[4*FW +: FW] = orig;
        clear_log();
        c0 = cyc;
        cycle();
        empty_in = '1;
        cycle();
        sw_busy = 5'b10000;
        cycle();
        frame_in[4*FW +: FW] = ~orig;
        repeat (9) cycle();
        sw_busy = '0;
        repeat (2) cycle();
        check_val("busy_issue", qat(iss_rr, 0), 4);
        check_val("busy_issue_cycle", qat(iss_cyc, 0) - c0, 12);
        check_val("busy_held_frame", last_info, {orig[31:24], 7'd0, orig[16], orig[15:0]});

        // Reset in the cycle after RD aborts the operation; channel 0 first afterwards
        empty_in = 5'b11101;
        clear_log();
        cycle();
        empty_in = '0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        empty_in = '1;
        repeat (3) cycle();
        check_val("post_rst_first", qat(iss_rr, 0), 0);
        check_val("post_rst_issue_count", iss_rr.size(), 1);
        check_val("post_rst_cnt", 32'(r_cnt), 1);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            empty_in = 5'($urandom());
            full_in  = 5'($urandom() & $urandom());
            sw_busy  = 5'($urandom() & $urandom() & $urandom());
            rst      = ($urandom_range(0, 79) == 0);
            for (int k = 0; k < N; k++) frame_in[k*FW +: FW] = $urandom();
            cycle();
        end

        // Fixed priority with channels 0 and 4 loaded; counter saturation
        rst = 1'b1; empty_in = '1; full_in = '0; sw_busy = '0;
        repeat (2) cycle();
        rst = 1'b0;
        empty_in = 5'b01110;
        clear_log();
        repeat (2) cycle();
        force dut_fp.issue_cnt_q = 16'hFFFD;
        m_cnt[1] = 32'hFFFD;
        #1;
        release dut_fp.issue_cnt_q;
        repeat (40) cycle();
        check_val("fp_saturated", 32'(f_cnt), 32'hFFFF);
        check_val("fp_issues_seen", 32'(iss_fp.size() >= 8), 1);
        for (int k = 0; k < iss_fp.size(); k++) check_val("fp_grant_ch0", iss_fp[k], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_sched_arb.md
TX_SCHED_ARB -- requirements
Module: tx_sched_arb

Interface
REQ-001 Parameter NUM_CH, default 5: number of switch channels (FIFO/switch pairs), range 2..16.
REQ-002 Parameter W_WIDTH, default 8: address and write-data width.
REQ-003 Parameter FRAME_WIDTH, fixed at 2*W_WIDTH+16: frame layout {op_id[7:0], ctrl[7:0], addr[W_WIDTH-1:0], wr_data[W_WIDTH-1:0]}, MSB first; ctrl[0] is wr_rd_s, ctrl[7:1] reserved and ignored.
REQ-004 Parameter ARB_MODE, default 0: 0 is round-robin, 1 is fixed priority with the lowest index winning.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 empty_in  in  NUM_CH  per-channel FIFO empty flag.
REQ-008 full_in  in  NUM_CH  per-channel FIFO full flag.
REQ-009 sw_busy  in  NUM_CH  per-switch busy flag; the scheduler issues nothing to a busy switch.
REQ-010 frame_in  in  NUM_CH*FRAME_WIDTH  flattened FIFO read data; channel k occupies bits [k*FRAME_WIDTH +: FRAME_WIDTH].
REQ-011 fifo_rd_en  out  NUM_CH  one-hot FIFO read strobe.
REQ-012 sel_en  out  NUM_CH  one-hot switch select, asserted for one cycle per operation.
REQ-013 addr, wr_data  out  W_WIDTH each  operation fields, valid while sel_en is non-zero.
REQ-014 wr_rd_s  out  1  1 for write, 0 for read; valid while sel_en is non-zero.
REQ-015 op_id  out  8  operation tag for the receive path, valid while op_valid is 1.
REQ-016 op_valid  out  1  one-cycle pulse, coincident with sel_en.
REQ-017 issue_cnt  out  16  number of operations issued; saturates at 16'hFFFF.

Function
REQ-018 An eligible channel is one with empty_in=0 and sw_busy=0.
REQ-019 The FSM has four states: IDLE, RD, CAP, ISSUE.
REQ-020 IDLE: if any channel is eligible, the arbiter registers a grant g and the FSM moves to RD; otherwise it stays in IDLE.
REQ-021 RD: fifo_rd_en[g]=1 for exactly this one cycle; next state is CAP.
REQ-022 CAP: the frame_in slice for g is captured into the frame register (FIFO data is valid one cycle after rd_en); next state is ISSUE.
REQ-023 ISSUE with sw_busy[g]=0: sel_en[g]=1, addr, wr_data, wr_rd_s and op_id are driven from the frame register, op_valid=1, issue_cnt increments, and the FSM returns to IDLE.
REQ-024 ISSUE with sw_busy[g]=1: the FSM stays in ISSUE, sel_en=0 and op_valid=0, and the captured frame is held without loss until busy clears.
REQ-025 Minimum spacing between issues is 4 cycles (grant to issue is 3 cycles).
REQ-026 Urgency: if any eligible channel also has full_in=1, arbitration is restricted to the eligible full channels.
REQ-027 Round-robin: the search starts at last_grant+1 modulo NUM_CH; the pointer updates only on a grant and resets to NUM_CH-1, so channel 0 has first priority.
REQ-028 Fixed priority: the lowest-index candidate wins.
REQ-029 empty_in or sw_busy changing after the grant does not cancel the operation in progress.
REQ-030 At most one bit of fifo_rd_en is set and at most one bit of sel_en is set in any cycle; their indices equal g.
REQ-031 When sel_en=0, addr, wr_data, wr_rd_s and op_id are driven to 0.

Reset
REQ-032 While rst=1: state is IDLE, fifo_rd_en=0, sel_en=0, addr=0, wr_data=0, wr_rd_s=0, op_id=0, op_valid=0, issue_cnt=0, frame register=0, and the RR pointer is NUM_CH-1.
REQ-033 Reset asserted mid-operation, in any state, aborts the operation with no further strobes; the FIFO entry already popped is discarded.

Structure
REQ-034 The shared package tx_sched_pkg holds the FSM state enum, the frame field offsets/widths, and the ARB_MODE encodings.
REQ-035 The arbiter is one sub-module, tx_arb, which is combinational from candidates and pointer and is parametrised by NUM_CH and ARB_MODE; the top module owns the pointer register.

Verification
REQ-036 NUM_CH=5, RR, channels 0..4 non-empty, none busy or full -> grants in the order 0,1,2,3,4,0; sel_en one-hot; one issue every 4 cycles.
REQ-037 Channel 2 frame 32'hA5_01_3C_7E -> sel_en=5'b00100, addr=8'h3C, wr_data=8'h7E, wr_rd_s=1, op_id=8'hA5, op_valid for one cycle, 3 cycles after the grant.
REQ-038 Channels 1 and 3 non-empty, full_in[3]=1, pointer at 0 -> channel 3 is granted first, then channel 1.
REQ-039 sw_busy[4]=1 asserted in CAP for 10 cycles -> no sel_en during those cycles; sel_en=5'b10000 with the held frame the cycle after busy clears.
REQ-040 rst=1 in the cycle after RD -> all outputs are 0 next cycle; after release, channel 0 is granted first and issue_cnt=0.
REQ-041 ARB_MODE=1 with channels 0 and 4 non-empty continuously -> channel 0 is always granted; issue_cnt saturates at 16'hFFFF when preloaded near its limit.
